// File: rtl/aesl_deadlock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aesl_deadlock_pkg
// Purpose  : Shared types and width helpers for the parametrised deadlock
//            monitor.
// Revision : 1.0 - initial release
// ============================================================================
package aesl_deadlock_pkg;

  // Monitor states: idle watching, timing a stall, deadlock latched.
  typedef enum logic [1:0] {
    ST_WATCH    = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_DEADLOCK = 2'd2
  } state_t;

  // Width of an index/counter able to hold values 0..n-1, never below 1 bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aesl_deadlock_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : aesl_deadlock_prio_enc
// Purpose  : Lowest-set-bit encoder: N request bits -> index of the lowest
//            set bit plus a valid flag. Index is 0 when nothing is set.
// Revision : 1.0 - initial release
// ============================================================================
module aesl_deadlock_prio_enc #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the top down so the last (lowest) set bit wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aesl_deadlock_param_monitor.sv
`default_nettype none
// ============================================================================
// Module   : aesl_deadlock_param_monitor
// Purpose  : Declares a kernel deadlock once the stall condition has held for
//            BLOCK_THRESH consecutive enabled cycles, snapshots the blocked
//            channels/instances at entry and counts deadlock duration.
// Revision : 1.0 - initial release
// ============================================================================
module aesl_deadlock_param_monitor
  import aesl_deadlock_pkg::*;
#(
  parameter int N_AXIS       = 2,
  parameter int N_INST       = 3,
  parameter int BLOCK_THRESH = 16,
  parameter int CYC_W        = 32
) (
  input  logic                                   kernel_monitor_clock,
  input  logic                                   kernel_monitor_reset,
  input  logic                                   enable,
  input  logic                                   clear,
  input  logic [N_AXIS-1:0]                      axis_block_sigs,
  input  logic [N_INST-1:0]                      inst_idle_sigs,
  input  logic [N_INST-1:0]                      inst_block_sigs,
  output logic                                   block,
  output logic                                   suspect,
  output logic [N_AXIS-1:0]                      axis_mask,
  output logic [N_INST-1:0]                      inst_mask,
  output logic [clog2_min1(N_AXIS)-1:0]          first_axis_idx,
  output logic [CYC_W-1:0]                       block_cycles
);

  localparam int                IDX_W      = clog2_min1(N_AXIS);
  localparam int                CNT_W      = clog2_min1(BLOCK_THRESH + 1);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(BLOCK_THRESH - 1);
  localparam logic [CYC_W-1:0]  C_CYC_MAX  = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_cond;
  logic               w_enter_dl;
  logic [IDX_W-1:0]   w_first_idx;
  logic               w_first_vld;

  // Every instance is idle or blocked, and something is actually blocked.
  // All-idle with no block bits is a quiescent kernel, not a stall.
  assign w_cond = (&(inst_idle_sigs | inst_block_sigs)) &
                  ((|axis_block_sigs) | (|inst_block_sigs));

  aesl_deadlock_prio_enc #(
    .N     (N_AXIS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_vec   (axis_block_sigs),
    .o_idx   (w_first_idx),
    .o_valid (w_first_vld)
  );

  // Next-state and stall-count logic; clear overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clear) begin
      w_state_nxt = ST_WATCH;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_WATCH: begin
          if (enable && w_cond) begin
            if (BLOCK_THRESH == 1) begin
              w_state_nxt = ST_DEADLOCK;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_SUSPECT;
              w_cnt_nxt   = CNT_W'(1);
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
        ST_SUSPECT: begin
          if (!enable || !w_cond) begin
            w_state_nxt = ST_WATCH;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_CNT_LAST) begin
            w_state_nxt = ST_DEADLOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_DEADLOCK: begin
          w_state_nxt = ST_DEADLOCK;
        end
        default: begin
          w_state_nxt = ST_WATCH;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_enter_dl = (w_state_nxt == ST_DEADLOCK) && (r_state != ST_DEADLOCK);

  // State and stall-counter registers.
  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
    if (!kernel_monitor_reset) begin
      r_state <= ST_WATCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Snapshot capture on deadlock entry and saturating duration counter.
  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
    if (!kernel_monitor_reset) begin
      axis_mask      <= '0;
      inst_mask      <= '0;
      first_axis_idx <= '0;
      block_cycles   <= '0;
    end else if (clear) begin
      axis_mask      <= '0;
      inst_mask      <= '0;
      first_axis_idx <= '0;
      block_cycles   <= '0;
    end else if (w_enter_dl) begin
      axis_mask      <= axis_block_sigs;
      inst_mask      <= inst_block_sigs;
      first_axis_idx <= w_first_vld ? w_first_idx : '0;
      block_cycles   <= CYC_W'(1);
    end else if ((r_state == ST_DEADLOCK) && (block_cycles != C_CYC_MAX)) begin
      block_cycles   <= block_cycles + CYC_W'(1);
    end
  end

  assign block   = (r_state == ST_DEADLOCK);
  assign suspect = (r_state == ST_SUSPECT);

endmodule
`default_nettype wire

// File: tb/tb_aesl_deadlock_param_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_aesl_deadlock_param_monitor
// Purpose  : Scoreboard bench: each driven cycle pushes the expected outputs
//            from a run-length reference model; a monitor pops and compares
//            after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aesl_deadlock_param_monitor;

  localparam int NA = 2;
  localparam int NI = 3;
  localparam int TH = 4;
  localparam int CW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          clr   = 1'b0;
  logic [NA-1:0] axis  = '0;
  logic [NI-1:0] idle  = '0;
  logic [NI-1:0] blk   = '0;

  logic          o_block;
  logic          o_suspect;
  logic [NA-1:0] o_axis_mask;
  logic [NI-1:0] o_inst_mask;
  logic [0:0]    o_first_idx;
  logic [CW-1:0] o_cycles;

  aesl_deadlock_param_monitor #(
    .N_AXIS       (NA),
    .N_INST       (NI),
    .BLOCK_THRESH (TH),
    .CYC_W        (CW)
  ) dut (
    .kernel_monitor_clock (clk),
    .kernel_monitor_reset (rst_n),
    .enable               (en),
    .clear                (clr),
    .axis_block_sigs      (axis),
    .inst_idle_sigs       (idle),
    .inst_block_sigs      (blk),
    .block                (o_block),
    .suspect              (o_suspect),
    .axis_mask            (o_axis_mask),
    .inst_mask            (o_inst_mask),
    .first_axis_idx       (o_first_idx),
    .block_cycles         (o_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int b;
    int s;
    int am;
    int im;
    int ix;
    int bc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: length of the current enabled-stall run plus latched data.
  int m_run  = 0;
  int m_dead = 0;
  int m_am   = 0;
  int m_im   = 0;
  int m_ix   = 0;
  int m_cyc  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic e, input logic c, input logic [NA-1:0] a,
                      input logic [NI-1:0] id, input logic [NI-1:0] bl,
                      input logic r);
    int   all_ok;
    int   any_blk;
    exp_t ex;
    @(negedge clk);
    en = e; clr = c; axis = a; idle = id; blk = bl; rst_n = r;
    all_ok  = 1;
    any_blk = 0;
    for (int j = 0; j < NI; j++) begin
      if (!(id[j] || bl[j])) all_ok = 0;
      if (bl[j]) any_blk = 1;
    end
    for (int i = 0; i < NA; i++) if (a[i]) any_blk = 1;
    if (!r || c) begin
      m_run = 0; m_dead = 0; m_am = 0; m_im = 0; m_ix = 0; m_cyc = 0;
    end else if (m_dead != 0) begin
      if (m_cyc < (1 << CW) - 1) m_cyc++;
    end else if (e && all_ok != 0 && any_blk != 0) begin
      m_run++;
      if (m_run >= TH) begin
        m_dead = 1;
        m_run  = 0;
        m_am   = int'(a);
        m_im   = int'(bl);
        m_ix   = 0;
        for (int i = NA - 1; i >= 0; i--) if (a[i]) m_ix = i;
        m_cyc  = 1;
      end
    end else begin
      m_run = 0;
    end
    ex.b  = m_dead;
    ex.s  = (m_dead == 0 && m_run > 0) ? 1 : 0;
    ex.am = m_am;
    ex.im = m_im;
    ex.ix = m_ix;
    ex.bc = m_cyc;
    q.push_back(ex);
  endtask

  task automatic hold(input int n, input logic e, input logic [NA-1:0] a,
                      input logic [NI-1:0] id, input logic [NI-1:0] bl);
    repeat (n) step(e, 1'b0, a, id, bl, 1'b1);
  endtask

  // Monitor: compares every registered output just after each rising edge.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        ex = q.pop_front();
        chk("block",          int'(o_block),     ex.b);
        chk("suspect",        int'(o_suspect),   ex.s);
        chk("axis_mask",      int'(o_axis_mask), ex.am);
        chk("inst_mask",      int'(o_inst_mask), ex.im);
        chk("first_axis_idx", int'(o_first_idx), ex.ix);
        chk("block_cycles",   int'(o_cycles),    ex.bc);
      end
    end
  end

  initial begin
    logic          e, c, r;
    logic [NA-1:0] a;
    logic [NI-1:0] id, bl;

    // Reset held, then released.
    repeat (3) step(1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("reset_block",  int'(o_block),  0);
    chk("reset_cycles", int'(o_cycles), 0);

    // Basic deadlock: idle=001, block=110, axis=10.
    hold(6, 1'b1, 2'b10, 3'b001, 3'b110);
    step(1'b1, 1'b1, 2'b10, 3'b001, 3'b110, 1'b1);

    // Single-cycle drop after 3 stall cycles restarts timing.
    hold(3, 1'b1, 2'b10, 3'b001, 3'b110);
    hold(1, 1'b1, 2'b00, 3'b001, 3'b000);
    hold(6, 1'b1, 2'b10, 3'b001, 3'b110);
    step(1'b1, 1'b1, '0, '0, '0, 1'b1);

    // All idle, nothing blocked: never a stall.
    hold(100, 1'b1, 2'b00, 3'b111, 3'b000);

    // Enable low suppresses detection.
    hold(8, 1'b0, 2'b01, 3'b001, 3'b110);

    // Deadlock held, then inputs released: stays sticky, masks frozen.
    hold(13, 1'b1, 2'b11, 3'b100, 3'b011);
    hold(5, 1'b0, 2'b00, 3'b000, 3'b000);
    step(1'b1, 1'b1, 2'b11, 3'b100, 3'b011, 1'b1);
    hold(2, 1'b1, 2'b00, 3'b000, 3'b000);

    // Long deadlock: duration counter saturates.
    hold(44, 1'b1, 2'b01, 3'b111, 3'b001);
    step(1'b1, 1'b1, '0, '0, '0, 1'b1);

    // Asynchronous reset while suspect with count 3.
    hold(3, 1'b1, 2'b10, 3'b001, 3'b110);
    step(1'b1, 1'b0, 2'b10, 3'b001, 3'b110, 1'b0);
    #1;
    chk("async_rst_suspect", int'(o_suspect), 0);
    chk("async_rst_block",   int'(o_block),   0);
    hold(6, 1'b1, 2'b10, 3'b001, 3'b110);
    step(1'b1, 1'b1, '0, '0, '0, 1'b1);

    // Randomized traffic biased toward stall patterns.
    for (int k = 0; k < 400; k++) begin
      e  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 149) != 0);
      a  = NA'($urandom);
      bl = NI'($urandom);
      if ($urandom_range(0, 3) != 0) id = (~bl) | NI'($urandom);
      else                           id = NI'($urandom);
      step(e, c, a, id, bl, r);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
